// File: rtl/serial_negate.sv
// serial_negate: bit-serial two's-complement negation.
// An operand is captured in IDLE, walked LSB-first for WIDTH cycles using the
// "copy up to and including the first 1, then invert" rule, and the result
// is presented in DONE until the downstream side accepts it.
module serial_negate #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             overflow,
   output logic             zero
);

   // Counter only has to reach WIDTH-1; keep at least one bit for WIDTH=2.
   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic signed [WIDTH-1:0] opnd_p0;   // operand, consumed from bit 0
   logic signed [WIDTH-1:0] res_p1;    // result, filled from the MSB side
   logic [CW-1:0]           cnt;       // bits processed in SHIFT
   logic                    seen_one;  // a 1 has already passed in the operand

   logic in_fire;
   logic out_fire;
   logic last_bit;
   logic res_bit;

   // One result bit: below (and at) the first 1 the operand is copied,
   // above it every bit is inverted.
   function automatic logic negate_bit(input logic opnd_bit, input logic seen);
      return opnd_bit ^ seen;
   endfunction

   // The most negative value is the only nonzero fixed point of negation,
   // so checking the result is equivalent to checking the operand.
   function automatic logic is_most_negative(input logic [WIDTH-1:0] v);
      return v == {1'b1, {(WIDTH-1){1'b0}}};
   endfunction

   assign in_fire  = (state == IDLE) && in_valid;
   assign out_fire = (state == DONE) && out_ready;
   assign last_bit = (cnt == LAST);
   assign res_bit  = negate_bit(opnd_p0[0], seen_one);

   // State register; reset forces IDLE without waiting for a clock.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic: capture -> WIDTH shift edges -> hold until accepted.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (in_fire) state_nxt = SHIFT;
         end
         SHIFT: begin
            if (last_bit) state_nxt = DONE;
         end
         DONE: begin
            if (out_fire) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Serial datapath: capture on input handshake, one bit per SHIFT cycle,
   // frozen otherwise so DONE outputs stay stable under backpressure.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         opnd_p0  <= '0;
         res_p1   <= '0;
         cnt      <= '0;
         seen_one <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_fire) begin
                  opnd_p0  <= in_data;
                  res_p1   <= '0;
                  cnt      <= '0;
                  seen_one <= 1'b0;
               end
            end
            SHIFT: begin
               opnd_p0  <= {1'b0, opnd_p0[WIDTH-1:1]};
               res_p1   <= {res_bit, res_p1[WIDTH-1:1]};
               seen_one <= seen_one | opnd_p0[0];
               cnt      <= last_bit ? '0 : cnt + 1'b1;
            end
            default: begin
               opnd_p0  <= opnd_p0;
               res_p1   <= res_p1;
               cnt      <= cnt;
               seen_one <= seen_one;
            end
         endcase
      end
   end

   // Outputs decode from registered state only; result fields are gated by DONE.
   always_comb begin
      in_ready  = (state == IDLE);
      out_valid = (state == DONE);
      out_data  = out_valid ? res_p1 : '0;
      zero      = out_valid && (res_p1 == '0);
      overflow  = out_valid && is_most_negative(res_p1);
   end

endmodule
